// File: rtl/skinny_pkg.sv
// Shared definitions for the nibble-serial SKINNY-64 S-box layer:
// the 4-bit S-box tables, the FSM state encoding and the nibble count.
package skinny_pkg;

  localparam int NIBBLES = 16;

  // Inverse S-box S4^-1, indexed by the input nibble value.
  localparam logic [3:0] S4_INV [0:15] = '{
    4'h3, 4'h4, 4'h6, 4'h8, 4'hC, 4'hA, 4'h1, 4'hE,
    4'h9, 4'h2, 4'h5, 4'h7, 4'h0, 4'hB, 4'hD, 4'hF
  };

  // Forward S-box S4, indexed by the input nibble value.
  localparam logic [3:0] S4_FWD [0:15] = '{
    4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
    4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/skinny_inv_sbox4.sv
// Combinational 4-bit SKINNY S-box lookup. Kept as its own module so that
// masking tools can treat it as the nonlinear gadget.
// Build option SKINNY_SBOX_FWD_EN adds mode_inv (1 = S4^-1, 0 = forward S4).
module skinny_inv_sbox4
  import skinny_pkg::*;
(
  input  logic [3:0] nib_i,
`ifdef SKINNY_SBOX_FWD_EN
  input  logic       mode_inv,
`endif
  output logic [3:0] nib_o
);

`ifdef SKINNY_SBOX_FWD_EN
  assign nib_o = mode_inv ? S4_INV[nib_i] : S4_FWD[nib_i];
`else
  assign nib_o = S4_INV[nib_i];
`endif

endmodule

// File: rtl/skinny_inv_sbox_serial.sv
// Nibble-serial inverse SKINNY-64 S-box layer. A 64-bit state is loaded
// into a shift register, NPC nibbles are substituted per cycle while the
// register rotates right, and after 16/NPC steps the original nibble order
// is restored. One state in flight at a time.
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; in_ready is high only in IDLE, out_valid only in DONE, and
// out_valid/out_data hold steady until the output transfer completes.
// Build option SKINNY_SBOX_FWD_EN adds port mode_inv, latched on accept.
module skinny_inv_sbox_serial
  import skinny_pkg::*;
#(
  parameter int STATE_W = 64,
  parameter int NPC     = 1
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] in_data,
`ifdef SKINNY_SBOX_FWD_EN
  input  logic               mode_inv,
`endif
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] out_data,
  output logic               busy
);

  localparam int SUB_W = 4 * NPC;
  localparam int STEPS = NIBBLES / NPC;
  localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [STATE_W-1:0] sr_q, sr_d;
  logic [SUB_W-1:0]   sub_out;
  logic [STATE_W-1:0] sr_rot;
`ifdef SKINNY_SBOX_FWD_EN
  logic               mode_q, mode_d;
`endif

  // The low NPC nibbles of the register go through the S-box gadgets.
  for (genvar g = 0; g < NPC; g++) begin : g_sbox
    skinny_inv_sbox4 u_sbox (
      .nib_i    (sr_q[4*g +: 4]),
`ifdef SKINNY_SBOX_FWD_EN
      .mode_inv (mode_q),
`endif
      .nib_o    (sub_out[4*g +: 4])
    );
  end

  // Substituted nibbles re-enter at the top: a right rotation by SUB_W.
  if (SUB_W >= STATE_W) begin : g_rot_full
    assign sr_rot = sub_out;
  end else begin : g_rot_part
    assign sr_rot = {sub_out, sr_q[STATE_W-1:SUB_W]};
  end

  // Next-state logic for FSM, step counter and shift register.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
`ifdef SKINNY_SBOX_FWD_EN
    mode_d  = mode_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sr_d    = in_data;
          cnt_d   = '0;
          state_d = BUSY;
`ifdef SKINNY_SBOX_FWD_EN
          mode_d  = mode_inv;
`endif
        end
      end
      BUSY: begin
        sr_d = sr_rot;
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any work in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
`ifdef SKINNY_SBOX_FWD_EN
      mode_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
`ifdef SKINNY_SBOX_FWD_EN
      mode_q  <= mode_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = sr_q;

endmodule

// File: tb/tb_skinny_inv_sbox_serial.sv
// Self-checking bench for skinny_inv_sbox_serial. Honours SKINNY_SBOX_FWD_EN.
module tb_skinny_inv_sbox_serial;

  localparam int TB_NPC = 1;
  localparam int LAT    = 16 / TB_NPC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
`ifdef SKINNY_SBOX_FWD_EN
  logic        mode_inv = 1'b1;
`endif
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];

  skinny_inv_sbox_serial #(.STATE_W(64), .NPC(TB_NPC)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
`ifdef SKINNY_SBOX_FWD_EN
    .mode_inv  (mode_inv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [3:0] inv_nib(input logic [3:0] x);
    case (x)
      4'h0: return 4'h3; 4'h1: return 4'h4; 4'h2: return 4'h6; 4'h3: return 4'h8;
      4'h4: return 4'hC; 4'h5: return 4'hA; 4'h6: return 4'h1; 4'h7: return 4'hE;
      4'h8: return 4'h9; 4'h9: return 4'h2; 4'hA: return 4'h5; 4'hB: return 4'h7;
      4'hC: return 4'h0; 4'hD: return 4'hB; 4'hE: return 4'hD; default: return 4'hF;
    endcase
  endfunction

  function automatic logic [3:0] fwd_nib(input logic [3:0] x);
    case (x)
      4'h0: return 4'hC; 4'h1: return 4'h6; 4'h2: return 4'h9; 4'h3: return 4'h0;
      4'h4: return 4'h1; 4'h5: return 4'hA; 4'h6: return 4'h2; 4'h7: return 4'hB;
      4'h8: return 4'h3; 4'h9: return 4'h8; 4'hA: return 4'h5; 4'hB: return 4'hD;
      4'hC: return 4'h4; 4'hD: return 4'hE; 4'hE: return 4'h7; default: return 4'hF;
    endcase
  endfunction

  function automatic logic [63:0] model(input logic [63:0] d, input logic inv);
    logic [63:0] r;
    for (int i = 0; i < 16; i++)
      r[4*i +: 4] = inv ? inv_nib(d[4*i +: 4]) : fwd_nib(d[4*i +: 4]);
    return r;
  endfunction

  // ---------------- drivers ----------------
  // Offer one state, wait for acceptance, push the required result.
  task automatic send_exp(input logic [63:0] d, input logic inv, input logic [63:0] exp);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      $display("FAIL send_ready: in_ready=%b required 1", in_ready);
      errors++;
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
`ifdef SKINNY_SBOX_FWD_EN
    mode_inv = inv;
`endif
    @(posedge clk);
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = {$urandom, $urandom};
`ifdef SKINNY_SBOX_FWD_EN
    mode_inv = ~inv;
`endif
  endtask

  task automatic send(input logic [63:0] d, input logic inv);
    send_exp(d, inv, model(d, inv));
  endtask

  // Wait for a result, compare with the scoreboard, hold it, then accept it.
  task automatic receive(input bit check_lat, input int hold);
    int k;
    logic [63:0] exp;
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (check_lat) begin
      checks++;
      if (k != LAT) begin
        $display("FAIL latency: got %0d edges required %0d", k, LAT);
        errors++;
      end
    end
    if (out_valid !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
      return;
    end
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty: got out_data=%h with nothing expected", out_data);
      return;
    end
    exp = exp_q.pop_front();
    checks++;
    if (out_data !== exp) begin
      $display("FAIL out_data: got %h required %h", out_data, exp);
      errors++;
    end
    repeat (hold) @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1 || out_data !== exp) begin
      $display("FAIL done_hold: valid=%b ready=%b busy=%b data=%h required 1 0 1 %h",
               out_valid, in_ready, busy, out_data, exp);
      errors++;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || out_data !== exp) begin
      $display("FAIL after_handshake: valid=%b ready=%b busy=%b data=%h required 0 1 0 %h",
               out_valid, in_ready, busy, out_data, exp);
      errors++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (out_data !== 64'h0 || out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL reset_state: data=%h valid=%b busy=%b ready=%b required 0 0 0 1",
               out_data, out_valid, busy, in_ready);
      errors++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    send_exp(64'h0, 1'b1, 64'h3333333333333333);
    out_ready = 1'b1;  // ignored while BUSY
    receive(1'b1, 0);
  endtask

  task automatic test_vectors();
    send_exp(64'h0123456789ABCDEF, 1'b1, 64'h3468CA1E92570BDF);
    receive(1'b1, 0);
    send_exp(64'hCCCCCCCCCCCCCCCC, 1'b1, 64'h0);
    receive(1'b1, 0);
    for (int i = 0; i < 4; i++) begin
      send({$urandom, $urandom}, 1'b1);
      receive(1'b1, 0);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] exp;
    int k;
    send(64'hA5F0_1E2D_3C4B_5A69, 1'b1);
    exp = exp_q[0];
    k = 0;
    while (!out_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      in_data  = {$urandom, $urandom};
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp || in_ready !== 1'b0) begin
        $display("FAIL backpressure: valid=%b data=%h ready=%b required 1 %h 0",
                 out_valid, out_data, in_ready, exp);
        errors++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    receive(1'b0, 0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      $display("FAIL ignored_pulses: busy=%b ready=%b required 0 1", busy, in_ready);
      errors++;
    end
  endtask

  task automatic test_reset_mid();
    send(64'h0F1E2D3C4B5A6978, 1'b1);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 64'h0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      $display("FAIL reset_mid: valid=%b data=%h ready=%b busy=%b required 0 0 1 0",
               out_valid, out_data, in_ready, busy);
      errors++;
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      $display("FAIL reset_release: ready=%b valid=%b required 1 0", in_ready, out_valid);
      errors++;
    end
    send_exp(64'h0123456789ABCDEF, 1'b1, 64'h3468CA1E92570BDF);
    receive(1'b1, 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      send({$urandom, $urandom}, 1'b1);
      receive(1'b1, $urandom_range(0, 3));
    end
  endtask

`ifdef SKINNY_SBOX_FWD_EN
  task automatic test_fwd();
    logic [63:0] mid;
    mid = model(64'hFEDCBA9876543210, 1'b0);
    send(64'hFEDCBA9876543210, 1'b0);
    receive(1'b1, 0);
    send_exp(mid, 1'b1, 64'hFEDCBA9876543210);
    receive(1'b1, 0);
    send_exp(64'h0, 1'b0, 64'hCCCCCCCCCCCCCCCC);
    receive(1'b1, 0);
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_zero();
    out_ready = 1'b0;
    test_vectors();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
`ifdef SKINNY_SBOX_FWD_EN
    test_fwd();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
